// File: rtl/stdp_array.sv
// stdp_array: pair-based spike-timing-dependent plasticity for N_CH synapses onto one neuron.
// Optional feature macro: STDP_LTD_EN enables the depression (LTD) path and the post timer.
// Without it, ltd_mask is tied to zero and only potentiation (LTP) occurs.
// Pipeline: event sampled in cycle k -> masks/steps registered (k+1) -> weights written (k+2).
// Reset is synchronous and active-high on rst_n (1 = reset).

module stdp_array #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned T_W     = 8,
  parameter int unsigned W_W     = 8,
  parameter int unsigned WIN     = 16,
  parameter int unsigned A_PLUS  = 16,
  parameter int unsigned A_MINUS = 8,
  parameter int unsigned TAU_SH  = 2,
  parameter int unsigned W_INIT  = 64,
  parameter int unsigned W_MAX   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      pre_spike,
  input  logic                 post_spike,
  input  logic                 learn_en,
  output logic [N_CH*W_W-1:0]  weight,
  output logic [N_CH-1:0]      ltp_mask,
  output logic [N_CH-1:0]      ltd_mask,
  output logic                 update_valid
);

  localparam logic [T_W-1:0] TMax = '1;
  localparam logic [T_W-1:0] WinT = T_W'(WIN);
  localparam logic [W_W:0]   WMaxX = (W_W+1)'(W_MAX);

  // dt in [1, WIN]; a saturated timer (no prior spike) is always outside the window
  function automatic logic in_win(input logic [T_W-1:0] dt);
    return (dt != '0) && (dt <= WinT);
  endfunction

  // Step halves every 2^TAU_SH cycles of dt; large shifts naturally yield zero
  function automatic logic [W_W-1:0] step_of(input logic [T_W-1:0] dt, input int unsigned amp);
    logic [T_W-1:0] sh;
    logic [31:0]    s;
    sh = (dt - T_W'(1)) >> TAU_SH;
    s  = 32'(amp) >> sh;
    return s[W_W-1:0];
  endfunction

  logic [T_W-1:0]  pre_timer_q [N_CH];
  logic [N_CH-1:0] ltp_d, ltp_q;
  logic [N_CH-1:0] ltd_d;
  logic [W_W-1:0]  step_d [N_CH];
  logic [W_W-1:0]  step_q [N_CH];
  logic            valid_q;
  logic [W_W-1:0]  weight_q [N_CH];
  logic [W_W-1:0]  weight_d [N_CH];

  // Per-channel pre timers: load 1 on spike, otherwise count up and saturate
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst_n) begin
        pre_timer_q[i] <= TMax;
      end else if (pre_spike[i]) begin
        pre_timer_q[i] <= T_W'(1);
      end else if (pre_timer_q[i] != TMax) begin
        pre_timer_q[i] <= pre_timer_q[i] + T_W'(1);
      end
    end
  end

`ifdef STDP_LTD_EN
  logic [T_W-1:0]  post_timer_q;
  logic [N_CH-1:0] ltd_q;

  // Post timer, same load/saturate behaviour as the pre timers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      post_timer_q <= TMax;
    end else if (post_spike) begin
      post_timer_q <= T_W'(1);
    end else if (post_timer_q != TMax) begin
      post_timer_q <= post_timer_q + T_W'(1);
    end
  end

  assign ltd_mask = ltd_q;
`else
  assign ltd_mask = '0;
`endif

  // Event decode: LTP needs post=1 and LTD needs post=0, so they are mutually exclusive
  always_comb begin
    ltp_d = '0;
    ltd_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      step_d[i] = '0;
      if (learn_en && post_spike && !pre_spike[i] && in_win(pre_timer_q[i])) begin
        ltp_d[i]  = 1'b1;
        step_d[i] = step_of(pre_timer_q[i], A_PLUS);
      end
`ifdef STDP_LTD_EN
      else if (learn_en && pre_spike[i] && !post_spike && in_win(post_timer_q)) begin
        ltd_d[i]  = 1'b1;
        step_d[i] = step_of(post_timer_q, A_MINUS);
      end
`endif
    end
  end

  // Stage 1: register masks and steps; reset discards any pending update
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ltp_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) step_q[i] <= '0;
    end else begin
      ltp_q   <= ltp_d;
      valid_q <= |(ltp_d | ltd_d);
      for (int i = 0; i < N_CH; i++) step_q[i] <= step_d[i];
    end
  end

`ifdef STDP_LTD_EN
  // LTD mask register, reset alongside stage 1
  always_ff @(posedge clk) begin
    if (rst_n) ltd_q <= '0;
    else       ltd_q <= ltd_d;
  end
`endif

  // Weight next-state: one extra bit of headroom, clamp to [0, W_MAX]
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      logic [W_W:0] sum;
      logic [W_W:0] diff;
      sum         = {1'b0, weight_q[i]} + {1'b0, step_q[i]};
      diff        = {1'b0, weight_q[i]} - {1'b0, step_q[i]};
      weight_d[i] = weight_q[i];
      if (ltp_q[i]) begin
        weight_d[i] = (sum > WMaxX) ? WMaxX[W_W-1:0] : sum[W_W-1:0];
      end else if (ltd_mask[i]) begin
        weight_d[i] = diff[W_W] ? '0 : diff[W_W-1:0];
      end
    end
  end

  // Stage 2: weight storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst_n) weight_q[i] <= W_W'(W_INIT);
      else       weight_q[i] <= weight_d[i];
    end
  end

  // Flatten weights onto the output bus
  always_comb begin
    weight = '0;
    for (int i = 0; i < N_CH; i++) weight[i*W_W +: W_W] = weight_q[i];
  end

  assign ltp_mask     = ltp_q;
  assign update_valid = valid_q;

endmodule
